pc_fetch_ctrl: RTL and testbench

Parametrised program-counter controller for the pipelined core's IF stage. It extends the basic stallable PC register with:
- a configurable width, reset vector and increment
- a redirect (branch/jump) input from EX
- a pending-redirect buffer, so a redirect that arrives during a stall is not lost
- a one-cycle post-reset boot bubble
- a fetch_valid qualifier for the instruction memory and IF/ID register

---
 rtl/pc_fetch_ctrl.sv | 157 +++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl -- program-counter controller for the IF stage.
//
// Holds the fetch PC, advances it by INC when the hazard unit allows,
// takes redirects from EX, and buffers a redirect that arrives during
// a stall so it is applied once the stall releases. The first edge after
// reset is a boot bubble that presents RESET_VECTOR as the first fetch.
//
// Optional feature: define PC_ALIGN_CHECK_EN to replace misaligned
// redirect targets with TRAP_VECTOR and pulse misalign_trap.
//
// Ports:
//   clk              rising-edge clock
//   reset            asynchronous, active-low reset
//   PCWrite          1 = PC may advance, 0 = stall
//   redirect_valid   redirect request from EX
//   redirect_target  redirect destination (XLEN bits)
//   PC_Out           registered fetch address
//   fetch_valid      registered, PC_Out is a real fetch this cycle
//   redirect_pending registered, a buffered redirect is waiting
//   misalign_trap    one-cycle pulse when TRAP_VECTOR is first shown

module pc_fetch_ctrl #(
  parameter int unsigned     XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     INC          = 4,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(64'h100)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            PCWrite,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic [XLEN-1:0] PC_Out,
  output logic            fetch_valid,
  output logic            redirect_pending,
  output logic            misalign_trap
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] INC_W = XLEN'(INC);

  state_t          state, state_next;
  logic [XLEN-1:0] pend_target, pend_target_next;
  logic [XLEN-1:0] pc_next;
  logic            fetch_valid_next;
  logic            pending_next;
  logic            apply_redirect;
  logic [XLEN-1:0] apply_target;

`ifdef PC_ALIGN_CHECK_EN
  // INC is a power of two, so its low bits form the alignment mask.
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INC - 1);
  logic misaligned;
  logic trap_next;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= BOOT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      BOOT:    state_next = redirect_valid ? PEND : RUN;
      RUN:     if (redirect_valid && !PCWrite) state_next = PEND;
      PEND:    if (PCWrite) state_next = RUN;
      default: state_next = BOOT;
    endcase
  end

  // Next values of the registered outputs and the redirect buffer.
  // apply_redirect marks the edge on which a target (direct or buffered)
  // is loaded into the PC; the alignment check hooks in only there.
  always_comb begin
    pc_next          = PC_Out;
    fetch_valid_next = fetch_valid;
    pending_next     = redirect_pending;
    pend_target_next = pend_target;
    apply_redirect   = 1'b0;
    apply_target     = redirect_target;
    case (state)
      BOOT: begin
        fetch_valid_next = 1'b1;
        if (redirect_valid) begin
          pend_target_next = redirect_target;
          pending_next     = 1'b1;
        end
      end
      RUN: begin
        if (redirect_valid && PCWrite) begin
          apply_redirect = 1'b1;
        end else if (redirect_valid) begin
          pend_target_next = redirect_target;
          fetch_valid_next = 1'b0;
          pending_next     = 1'b1;
        end else if (PCWrite) begin
          pc_next = PC_Out + INC_W;
        end
      end
      PEND: begin
        if (PCWrite) begin
          // A redirect arriving on the release edge is newer than the buffer.
          apply_redirect   = 1'b1;
          apply_target     = redirect_valid ? redirect_target : pend_target;
          fetch_valid_next = 1'b1;
          pending_next     = 1'b0;
        end else if (redirect_valid) begin
          pend_target_next = redirect_target;
        end
      end
      default: begin
        fetch_valid_next = 1'b0;
        pending_next     = 1'b0;
      end
    endcase

`ifdef PC_ALIGN_CHECK_EN
    misaligned = |(apply_target & ALIGN_MASK);
    trap_next  = apply_redirect && misaligned;
    if (apply_redirect) pc_next = misaligned ? TRAP_VECTOR : apply_target;
`else
    if (apply_redirect) pc_next = apply_target;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PC_Out           <= RESET_VECTOR;
      fetch_valid      <= 1'b0;
      redirect_pending <= 1'b0;
      pend_target      <= '0;
    end else begin
      PC_Out           <= pc_next;
      fetch_valid      <= fetch_valid_next;
      redirect_pending <= pending_next;
      pend_target      <= pend_target_next;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) misalign_trap <= 1'b0;
    else        misalign_trap <= trap_next;
  end
`else
  // Constant zero; the AND keeps TRAP_VECTOR referenced so the parameter
  // list is identical in both builds.
  assign misalign_trap = 1'b0 & (|TRAP_VECTOR);
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pw = 1'b0;
  logic        rv = 1'b0;
  logic [63:0] tgt = '0;
  logic [63:0] pc;
  logic        fv, pend, trap;

  logic        pw8 = 1'b0;
  logic        rv8 = 1'b0;
  logic [7:0]  tgt8 = '0;
  logic [7:0]  pc8;
  logic        fv8, pend8, trap8;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pc_fetch_ctrl dut (
    .clk(clk), .reset(reset), .PCWrite(pw), .redirect_valid(rv),
    .redirect_target(tgt), .PC_Out(pc), .fetch_valid(fv),
    .redirect_pending(pend), .misalign_trap(trap)
  );

  pc_fetch_ctrl #(.XLEN(8), .RESET_VECTOR(8'hF8), .INC(4), .TRAP_VECTOR(8'h80)) dut8 (
    .clk(clk), .reset(reset), .PCWrite(pw8), .redirect_valid(rv8),
    .redirect_target(tgt8), .PC_Out(pc8), .fetch_valid(fv8),
    .redirect_pending(pend8), .misalign_trap(trap8)
  );

`ifdef PC_ALIGN_CHECK_EN
  localparam bit          ALIGN_ON = 1'b1;
  localparam logic [63:0] MIS_PC   = 64'h100;
  localparam logic [63:0] MIS_PC2  = 64'h104;
  localparam logic [63:0] MIS_BUF  = 64'h100;
`else
  localparam bit          ALIGN_ON = 1'b0;
  localparam logic [63:0] MIS_PC   = 64'h82;
  localparam logic [63:0] MIS_PC2  = 64'h86;
  localparam logic [63:0] MIS_BUF  = 64'h2A6;
`endif

  typedef struct {
    bit          p;
    bit          r;
    logic [63:0] t;
    logic [63:0] e_pc;
    bit          e_fv;
    bit          e_pend;
    bit          e_trap;
  } vec_t;

  vec_t vecs[$];

  // Reference model: what the fetch unit should be showing, tracked as
  // "are we in the boot bubble", "is a redirect waiting" and its address.
  logic [63:0] m_pc, m_buf;
  bit          m_fv, m_pend, m_trap, m_boot;

  function automatic void modelReset();
    m_pc = 64'h0; m_buf = 64'h0; m_fv = 0; m_pend = 0; m_trap = 0; m_boot = 1;
  endfunction

  function automatic void modelLoad(input logic [63:0] t);
    bit bad_align;
    bad_align = ALIGN_ON && (t % 4 != 0);
    m_trap = bad_align;
    m_pc = bad_align ? 64'h100 : t;
  endfunction

  function automatic void modelStep(input bit p, input bit r, input logic [63:0] t);
    m_trap = 0;
    if (m_boot) begin
      m_boot = 0;
      m_fv = 1;
      if (r) begin m_pend = 1; m_buf = t; end
    end else if (m_pend) begin
      if (p) begin
        modelLoad(r ? t : m_buf);
        m_pend = 0;
        m_fv = 1;
      end else if (r) begin
        m_buf = t;
      end
    end else begin
      if (r && p) modelLoad(t);
      else if (r) begin m_buf = t; m_pend = 1; m_fv = 0; end
      else if (p) m_pc = m_pc + 64'd4;
    end
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] e_pc,
                             input bit e_fv, input bit e_pend, input bit e_trap);
    total++;
    if (pc !== e_pc) begin
      bad++; $display("[TB] FAIL %s PC_Out got=%h exp=%h", name, pc, e_pc);
    end
    total++;
    if (fv !== e_fv) begin
      bad++; $display("[TB] FAIL %s fetch_valid got=%b exp=%b", name, fv, e_fv);
    end
    total++;
    if (pend !== e_pend) begin
      bad++; $display("[TB] FAIL %s redirect_pending got=%b exp=%b", name, pend, e_pend);
    end
    total++;
    if (trap !== e_trap) begin
      bad++; $display("[TB] FAIL %s misalign_trap got=%b exp=%b", name, trap, e_trap);
    end
  endtask

  task automatic applyStimulus(input bit p, input bit r, input logic [63:0] t);
    @(negedge clk);
    pw = p; rv = r; tgt = t;
    @(posedge clk);
    #1;
  endtask

  function automatic void addVec(input bit p, input bit r, input logic [63:0] t,
                                 input logic [63:0] e_pc, input bit e_fv,
                                 input bit e_pend, input bit e_trap);
    vec_t v;
    v.p = p; v.r = r; v.t = t; v.e_pc = e_pc;
    v.e_fv = e_fv; v.e_pend = e_pend; v.e_trap = e_trap;
    vecs.push_back(v);
  endfunction

  initial begin
    // Boot and sequential fetch up to 0x20
    addVec(1, 0, 0, 64'h0, 1, 0, 0);
    for (int i = 1; i <= 8; i++) addVec(1, 0, 0, 64'(4 * i), 1, 0, 0);
    // Direct redirect
    addVec(1, 1, 64'h80, 64'h80, 1, 0, 0);
    addVec(1, 0, 0, 64'h84, 1, 0, 0);
    // Redirect during stall is buffered, then applied on release
    addVec(1, 1, 64'h40, 64'h40, 1, 0, 0);
    addVec(0, 1, 64'h200, 64'h40, 0, 1, 0);
    addVec(0, 0, 0, 64'h40, 0, 1, 0);
    addVec(0, 0, 0, 64'h40, 0, 1, 0);
    addVec(1, 0, 0, 64'h200, 1, 0, 0);
    // Newer redirect while stalled overwrites the buffer
    addVec(0, 1, 64'h200, 64'h200, 0, 1, 0);
    addVec(0, 1, 64'h300, 64'h200, 0, 1, 0);
    addVec(1, 0, 0, 64'h300, 1, 0, 0);
    // Redirect on the release edge beats the buffer
    addVec(0, 1, 64'h200, 64'h300, 0, 1, 0);
    addVec(1, 1, 64'h400, 64'h400, 1, 0, 0);
    addVec(0, 0, 0, 64'h400, 1, 0, 0);
    // Misaligned direct and buffered redirects
    addVec(1, 1, 64'h82, MIS_PC, 1, 0, ALIGN_ON);
    addVec(1, 0, 0, MIS_PC2, 1, 0, 0);
    addVec(0, 1, 64'h2A6, MIS_PC2, 0, 1, 0);
    addVec(1, 0, 0, MIS_BUF, 1, 0, ALIGN_ON);
    addVec(0, 0, 0, MIS_BUF, 1, 0, 0);
    // 64-bit wrap
    addVec(1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 0);
    addVec(1, 0, 0, 64'h0, 1, 0, 0);

    reset = 1'b0;
    pw = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset", 64'h0, 0, 0, 0);
    reset = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].p, vecs[i].r, vecs[i].t);
      checkOutput($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_fv,
                  vecs[i].e_pend, vecs[i].e_trap);
    end

    // Reset in PEND drops the buffered target; boot ignores PCWrite
    applyStimulus(1, 1, 64'h700);
    checkOutput("pre_pend", 64'h700, 1, 0, 0);
    applyStimulus(0, 1, 64'h500);
    checkOutput("pend_500", 64'h700, 0, 1, 0);
    reset = 1'b0;
    #1;
    checkOutput("async_reset", 64'h0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    applyStimulus(0, 0, 0);
    checkOutput("boot_nowrite", 64'h0, 1, 0, 0);
    applyStimulus(1, 0, 0);
    checkOutput("after_boot", 64'h4, 1, 0, 0);

    // 8-bit instance: has been sitting stalled at its reset vector
    applyStimulus(0, 0, 0);
    total++;
    if (pc8 !== 8'hF8 || fv8 !== 1'b1) begin
      bad++; $display("[TB] FAIL x8_hold pc=%h fv=%b exp pc=f8 fv=1", pc8, fv8);
    end
    @(negedge clk);
    pw8 = 1'b1;
    @(posedge clk); #1;
    total++;
    if (pc8 !== 8'hFC) begin
      bad++; $display("[TB] FAIL x8_fc got=%h exp=fc", pc8);
    end
    @(posedge clk); #1;
    total++;
    if (pc8 !== 8'h00 || fv8 !== 1'b1 || pend8 !== 1'b0 || trap8 !== 1'b0) begin
      bad++; $display("[TB] FAIL x8_wrap pc=%h fv=%b pend=%b trap=%b exp 00/1/0/0",
                      pc8, fv8, pend8, trap8);
    end
    @(negedge clk);
    pw8 = 1'b0;

    // Randomized run against the reference model
    reset = 1'b0;
    #1;
    modelReset();
    checkOutput("rand_reset", m_pc, m_fv, m_pend, m_trap);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int n = 0; n < 600; n++) begin
      bit          p, r;
      logic [63:0] t;
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b0;
        #1;
        modelReset();
        checkOutput("rand_midreset", m_pc, m_fv, m_pend, m_trap);
        @(posedge clk); #1;
        reset = 1'b1;
      end
      p = ($urandom_range(0, 3) != 0);
      r = m_boot ? 1'b0 : ($urandom_range(0, 2) == 0);
      t = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      applyStimulus(p, r, t);
      modelStep(p, r, t);
      checkOutput($sformatf("rand%0d", n), m_pc, m_fv, m_pend, m_trap);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
